// File: rtl/stream_demux_reg.sv
// Registered 1-to-N_OUT stream demultiplexer with a one-entry valid/ready slot per output channel.
// Define DEMUX_STATS_EN to add saturating per-channel handshake counters and a drop counter.
module stream_demux_reg #(
    parameter int DATA_W  = 8,
    parameter int N_OUT   = 4,
    parameter int CNT_W   = 16,
    localparam int SEL_W  = $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [DATA_W-1:0]       in_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    err_drop
`ifdef DEMUX_STATS_EN
    ,
    output logic [N_OUT*CNT_W-1:0]  stat_cnt,
    output logic [CNT_W-1:0]        drop_cnt
`endif
);

    logic [N_OUT-1:0]        sel_hit;
    logic                    sel_oob;
    logic                    slot_blocked;
    logic                    accept;
    logic [N_OUT-1:0]        valid_d;
    logic [N_OUT-1:0]        valid_q;
    logic [N_OUT*DATA_W-1:0] data_d;
    logic [N_OUT*DATA_W-1:0] data_q;
    logic                    err_drop_d;
    logic                    err_drop_q;

    // One-hot decode; an out-of-range select hits no channel, so N_OUT need not be a power of two.
    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < N_OUT; k++) begin
            sel_hit[k] = (32'(in_sel) == 32'(k));
        end
        sel_oob = (32'(in_sel) >= 32'(N_OUT));
    end

    // The selected slot only refuses a beat when it is full and its consumer is not draining it now.
    assign slot_blocked = |(sel_hit & valid_q & ~out_ready);
    assign in_ready     = en & (sel_oob | ~slot_blocked);
    assign accept       = in_valid & in_ready;

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        err_drop_d = accept & sel_oob;
        for (int k = 0; k < N_OUT; k++) begin
            if (accept && sel_hit[k]) begin
                valid_d[k]                   = 1'b1;
                data_d[k*DATA_W +: DATA_W]   = in_data;
            end else if (out_ready[k]) begin
                valid_d[k]                   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            data_q     <= '0;
            err_drop_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            err_drop_q <= err_drop_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err_drop  = err_drop_q;

`ifdef DEMUX_STATS_EN
    logic [N_OUT*CNT_W-1:0] stat_d;
    logic [N_OUT*CNT_W-1:0] stat_q;
    logic [CNT_W-1:0]       drop_d;
    logic [CNT_W-1:0]       drop_q;
    logic [CNT_W-1:0]       cur_cnt;

    // Counters saturate at all-ones rather than wrapping.
    always_comb begin
        stat_d  = stat_q;
        drop_d  = drop_q;
        cur_cnt = '0;
        for (int k = 0; k < N_OUT; k++) begin
            cur_cnt = stat_q[k*CNT_W +: CNT_W];
            if (valid_q[k] && out_ready[k] && (cur_cnt != {CNT_W{1'b1}})) begin
                stat_d[k*CNT_W +: CNT_W] = cur_cnt + 1'b1;
            end
        end
        if (err_drop_q && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
            drop_q <= '0;
        end else begin
            stat_q <= stat_d;
            drop_q <= drop_d;
        end
    end

    assign stat_cnt = stat_q;
    assign drop_cnt = drop_q;
`endif

endmodule
